// File: rtl/full_sub_core.sv
`default_nettype none
// ============================================================================
//  Module   : full_sub_core
//  Purpose  : Registered full subtractor, difference = (a - b - cin) mod 2^W,
//             borrow = 1 when a < b + cin. One cycle latency, valid-qualified.
//             Optional macro FULL_SUB_OVERFLOW_EN adds a registered signed
//             overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module full_sub_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] difference,
    output logic             borrow
`ifdef FULL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    // Borrow chain: br[0] is the incoming borrow, br[WIDTH] the outgoing one.
    logic [WIDTH:0]   w_br;
    logic [WIDTH-1:0] difference_d;
    logic             borrow_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] difference_q;
    logic             borrow_q;

    assign w_br[0] = cin;

    // Ripple chain of 1-bit full-subtractor cells.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i = i + 1) begin : g_cell
            assign difference_d[i] = a[i] ^ b[i] ^ w_br[i];
            assign w_br[i+1]       = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_br[i]);
        end
    endgenerate

    assign borrow_d = w_br[WIDTH];

    // Valid strobe follows in_valid by one cycle; cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
        end
    end

    // Result registers capture only on a valid input and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            difference_q <= '0;
            borrow_q     <= 1'b0;
        end else if (in_valid) begin
            difference_q <= difference_d;
            borrow_q     <= borrow_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign difference = difference_q;
    assign borrow     = borrow_q;

`ifdef FULL_SUB_OVERFLOW_EN
    logic overflow_d;
    logic overflow_q;

    // Signed overflow: operands differ in sign and the result sign differs
    // from the minuend's sign.
    assign overflow_d = (a[WIDTH-1] != b[WIDTH-1]) &
                        (difference_d[WIDTH-1] != a[WIDTH-1]);

    // Overflow flag shares the result register enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (in_valid) begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_full_sub_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_full_sub_core
//  Purpose  : Scoreboard bench for full_sub_core at WIDTH=1 and WIDTH=8.
//             Optional macro FULL_SUB_OVERFLOW_EN also checks overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_full_sub_core;

    typedef struct {
        logic [7:0] d;
        logic       br;
        logic       ov;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       v1, v8;
    logic [0:0] a1, b1;
    logic [7:0] a8, b8;
    logic       c1, c8;
    logic       ov1_o, ov8_o;
    logic [0:0] d1_o;
    logic [7:0] d8_o;
    logic       br1_o, br8_o, ovv1_o, ovv8_o;

    int checks   = 0;
    int failures = 0;

    exp_t q1[$];
    exp_t q8[$];

    full_sub_core #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .out_valid(ovv1_o), .difference(d1_o), .borrow(br1_o)
`ifdef FULL_SUB_OVERFLOW_EN
        , .overflow(ov1_o)
`endif
    );

    full_sub_core #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .out_valid(ovv8_o), .difference(d8_o), .borrow(br8_o)
`ifdef FULL_SUB_OVERFLOW_EN
        , .overflow(ov8_o)
`endif
    );

`ifndef FULL_SUB_OVERFLOW_EN
    assign ov1_o = 1'b0;
    assign ov8_o = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected-value helpers: difference and borrow are hand-computed in the
    // vector tables; signed overflow is derived from them.
    task automatic push1(input logic a, input logic b, input logic d, input logic br);
        exp_t e;
        e.d  = {7'd0, d};
        e.br = br;
        e.ov = (a != b) && (d != a);
        q1.push_back(e);
    endtask

    task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d, input logic br);
        exp_t e;
        e.d  = d;
        e.br = br;
        e.ov = (a[7] != b[7]) && (d[7] != a[7]);
        q8.push_back(e);
    endtask

    // Monitor: compare every valid output against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ovv1_o) begin
                if (q1.size() == 0) begin
                    chk("w1_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("w1_difference", {31'd0, d1_o}, {24'd0, e.d});
                    chk("w1_borrow", {31'd0, br1_o}, {31'd0, e.br});
`ifdef FULL_SUB_OVERFLOW_EN
                    chk("w1_overflow", {31'd0, ov1_o}, {31'd0, e.ov});
`endif
                end
            end
            if (ovv8_o) begin
                if (q8.size() == 0) begin
                    chk("w8_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("w8_difference", {24'd0, d8_o}, {24'd0, e.d});
                    chk("w8_borrow", {31'd0, br8_o}, {31'd0, e.br});
`ifdef FULL_SUB_OVERFLOW_EN
                    chk("w8_overflow", {31'd0, ov8_o}, {31'd0, e.ov});
`endif
                end
            end
        end
    end

    // Directed vectors: {a,b,cin} -> {difference,borrow}.
    logic [2:0] t1_in  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [1:0] t1_out [8] = '{2'b00,  2'b11,  2'b11,  2'b01,  2'b10,  2'b00,  2'b00,  2'b11};

    logic [7:0] t8_a  [8] = '{8'h00, 8'h80, 8'h05, 8'h5A, 8'h00, 8'hFF, 8'h10, 8'h7F};
    logic [7:0] t8_b  [8] = '{8'hFF, 8'h01, 8'h03, 8'h5A, 8'h00, 8'h00, 8'h20, 8'hFF};
    logic       t8_c  [8] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
    logic [7:0] t8_d  [8] = '{8'h00, 8'h7F, 8'h02, 8'h00, 8'hFF, 8'hFE, 8'hF0, 8'h80};
    logic       t8_br [8] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_w1_out_valid"}, {31'd0, ovv1_o}, 32'd0);
        chk({tag, "_w1_difference"}, {31'd0, d1_o}, 32'd0);
        chk({tag, "_w1_borrow"}, {31'd0, br1_o}, 32'd0);
        chk({tag, "_w8_out_valid"}, {31'd0, ovv8_o}, 32'd0);
        chk({tag, "_w8_difference"}, {24'd0, d8_o}, 32'd0);
        chk({tag, "_w8_borrow"}, {31'd0, br8_o}, 32'd0);
`ifdef FULL_SUB_OVERFLOW_EN
        chk({tag, "_w1_overflow"}, {31'd0, ov1_o}, 32'd0);
        chk({tag, "_w8_overflow"}, {31'd0, ov8_o}, 32'd0);
`endif
    endtask

    initial begin
        // Reset held with a live valid input: nothing may be captured.
        rst_n = 1'b0;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        v8 = 1'b1; a8 = 8'h01; b8 = 8'h00; c8 = 1'b0;
        #2;
        check_cleared("reset_async");
        repeat (3) tick();
        check_cleared("reset_held");

        // Release: the very next edge captures 1 - 0 - 0.
        rst_n = 1'b1;
        push1(1'b1, 1'b0, 1'b1, 1'b0);
        push8(8'h01, 8'h00, 8'h01, 1'b0);
        tick();

        // Back-to-back vectors: exhaustive WIDTH=1 alongside WIDTH=8 cases.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] in1;
            logic [1:0] out1;
            in1  = t1_in[i];
            out1 = t1_out[i];
            a1 = in1[2]; b1 = in1[1]; c1 = in1[0];
            push1(in1[2], in1[1], out1[1], out1[0]);
            a8 = t8_a[i]; b8 = t8_b[i]; c8 = t8_c[i];
            push8(t8_a[i], t8_b[i], t8_d[i], t8_br[i]);
            tick();
        end

        // Hold: one valid 1-0-0, then scrambled inputs with in_valid low.
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        push1(1'b1, 1'b0, 1'b1, 1'b0);
        a8 = 8'h80; b8 = 8'h01; c8 = 1'b0;
        push8(8'h80, 8'h01, 8'h7F, 1'b0);
        tick();
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b1; c1 = 1'b1;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'hFF; c8 = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("hold_w1_out_valid", {31'd0, ovv1_o}, 32'd0);
        chk("hold_w1_difference", {31'd0, d1_o}, 32'd1);
        chk("hold_w1_borrow", {31'd0, br1_o}, 32'd0);
        chk("hold_w8_out_valid", {31'd0, ovv8_o}, 32'd0);
        chk("hold_w8_difference", {24'd0, d8_o}, 32'h7F);
        chk("hold_w8_borrow", {31'd0, br8_o}, 32'd0);
`ifdef FULL_SUB_OVERFLOW_EN
        chk("hold_w8_overflow", {31'd0, ov8_o}, 32'd1);
`endif

        // Mid-stream reset: streaming vectors, reset pulsed between edges.
        tick();
        v1 = 1'b1; a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
        push1(1'b0, 1'b1, 1'b1, 1'b1);
        v8 = 1'b1; a8 = 8'h05; b8 = 8'h03; c8 = 1'b0;
        push8(8'h05, 8'h03, 8'h02, 1'b0);
        tick();
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        push1(1'b1, 1'b1, 1'b1, 1'b1);
        a8 = 8'h00; b8 = 8'hFF; c8 = 1'b1;
        push8(8'h00, 8'hFF, 8'h00, 1'b1);
        tick();
        // That last vector is now registered but not yet checked; reset drops it.
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0;
        #1;
        check_cleared("midreset");
        q1.delete();
        q8.delete();
        #2;
        rst_n = 1'b1;
        push1(1'b1, 1'b0, 1'b0, 1'b0);
        push8(8'h10, 8'h20, 8'hF0, 1'b1);
        tick();
        v1 = 1'b0;
        v8 = 1'b0;

        // Drain with a bounded wait.
        for (int n = 0; n < 10 && (q1.size() != 0 || q8.size() != 0); n++) begin
            tick();
        end
        @(negedge clk);
        #1;
        chk("drain_w1_pending", q1.size(), 32'd0);
        chk("drain_w8_pending", q8.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
